// File: rtl/lamp_arbiter_if.sv
// Switch-side bundle for the lamp arbiter: master/sensor/command inputs and the registered lamp outputs.
// The packed switch command bus is called cmd because int is a reserved word in SystemVerilog.
interface lamp_arbiter_if;
    logic        m;
    logic [15:0] s;
    logic [31:0] cmd;
    logic [1:0]  y;
    logic [3:0]  gnt;
    logic        valid;

    modport master (output m, s, cmd, input y, gnt, valid);
    modport slave  (input m, s, cmd, output y, gnt, valid);
endinterface

// File: rtl/lamp_arbiter.sv
// Round-robin lamp arbiter for 16 switches with hold window, max tenure and master override.
// Latency: 1 cycle, all outputs registered; no backpressure, the lamp driver always accepts.
module lamp_arbiter #(
    parameter int HOLD = 4,
    parameter int MAXT = 16
) (
    input  logic          clock,
    input  logic          reset_n,
    lamp_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, OWN, MASTER} state_t;

    localparam logic [7:0] HOLD_M1 = 8'(HOLD - 1);
    localparam logic [7:0] MAXT_M1 = 8'(MAXT - 1);

    state_t     state, state_nxt;
    logic [1:0] y_q, y_nxt;
    logic [3:0] gnt_q, gnt_nxt;
    logic [3:0] last_q, last_nxt;
    logic       valid_q, valid_nxt;
    logic [7:0] cnt_q, cnt_nxt;

    logic [3:0] rr_last, rr_gnt, pick;
    logic       own_req, others, do_grant, go_idle;

    // First requester strictly after x, wrapping; x itself is tried last.
    function automatic logic [3:0] rr(input logic [3:0] x, input logic [15:0] req);
        logic [3:0] idx;
        logic [3:0] sel;
        logic       hit;
        sel = x;
        hit = 1'b0;
        for (int d = 1; d <= 16; d++) begin
            idx = x + 4'(d);
            if (!hit && req[idx]) begin
                sel = idx;
                hit = 1'b1;
            end
        end
        return sel;
    endfunction

    always_comb begin
        rr_last = rr(last_q, bus.s);
        rr_gnt  = rr(gnt_q, bus.s);
        own_req = bus.s[gnt_q];
        others  = |(bus.s & ~(16'h0001 << gnt_q));
    end

    always_comb begin
        state_nxt = state;
        y_nxt     = y_q;
        gnt_nxt   = gnt_q;
        last_nxt  = last_q;
        valid_nxt = valid_q;
        cnt_nxt   = cnt_q;
        do_grant  = 1'b0;
        go_idle   = 1'b0;
        pick      = rr_last;

        case (state)
            IDLE, MASTER: begin
                if (|bus.s) do_grant = 1'b1;
                else        go_idle  = 1'b0 | 1'b1;
            end
            OWN: begin
                pick = rr_gnt;
                if (!own_req && cnt_q >= HOLD_M1) begin
                    if (|bus.s) do_grant = 1'b1;
                    else        go_idle  = 1'b1;
                end else if (own_req && cnt_q >= MAXT_M1 && others) begin
                    do_grant = 1'b1;
                end else begin
                    cnt_nxt = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
                    y_nxt   = bus.cmd[{gnt_q, 1'b0} +: 2];
                end
            end
            default: go_idle = 1'b1;
        endcase

        if (do_grant) begin
            state_nxt = OWN;
            gnt_nxt   = pick;
            last_nxt  = pick;
            cnt_nxt   = 8'd0;
            y_nxt     = bus.cmd[{pick, 1'b0} +: 2];
            valid_nxt = 1'b1;
        end else if (go_idle) begin
            state_nxt = IDLE;
            gnt_nxt   = 4'd0;
            cnt_nxt   = 8'd0;
            y_nxt     = 2'b00;
            valid_nxt = 1'b0;
        end

        // Master wins over any grant/release decided above; last is left alone.
        if (bus.m) begin
            state_nxt = MASTER;
            y_nxt     = bus.cmd[1:0];
            gnt_nxt   = 4'd0;
            valid_nxt = 1'b1;
            cnt_nxt   = 8'd0;
            last_nxt  = last_q;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            y_q     <= 2'b00;
            gnt_q   <= 4'd0;
            last_q  <= 4'd15;
            valid_q <= 1'b0;
            cnt_q   <= 8'd0;
        end else begin
            state   <= state_nxt;
            y_q     <= y_nxt;
            gnt_q   <= gnt_nxt;
            last_q  <= last_nxt;
            valid_q <= valid_nxt;
            cnt_q   <= cnt_nxt;
        end
    end

    assign bus.y     = y_q;
    assign bus.gnt   = gnt_q;
    assign bus.valid = valid_q;
endmodule

// File: tb/tb_lamp_arbiter.sv
// Self-checking bench for lamp_arbiter: reference model feeds a scoreboard, plus scenario checks.
module tb_lamp_arbiter;
    localparam int HOLD = 4;
    localparam int MAXT = 16;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    lamp_arbiter_if bus();

    lamp_arbiter #(.HOLD(HOLD), .MAXT(MAXT)) dut (
        .clock  (clock),
        .reset_n(reset_n),
        .bus    (bus)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Reference model state: mst 0=idle 1=own 2=master
    int         mst, eg, mcnt, mlast;
    logic [1:0] ey;
    logic       ev;
    logic [6:0] exp_q[$];
    logic [6:0] sb_exp;

    function automatic int rr_ref(int x, logic [15:0] req);
        for (int d = 1; d <= 16; d++)
            if (req[(x + d) % 16]) return (x + d) % 16;
        return -1;
    endfunction

    task automatic model_grant(int n);
        mst = 1; eg = n; mlast = n; mcnt = 0; ev = 1'b1;
        ey = bus.cmd[2*n +: 2];
    endtask

    task automatic model_idle();
        mst = 0; eg = 0; mcnt = 0; ey = 2'b00; ev = 1'b0;
    endtask

    task automatic step();
        logic own, oth;
        if (bus.m) begin
            mst = 2; ey = bus.cmd[1:0]; eg = 0; ev = 1'b1; mcnt = 0;
        end else if (mst != 1) begin
            if (bus.s != 16'd0) model_grant(rr_ref(mlast, bus.s));
            else model_idle();
        end else begin
            own = bus.s[eg];
            oth = (bus.s & ~(16'h0001 << eg)) != 16'd0;
            if (!own && mcnt >= HOLD - 1) begin
                if (oth) model_grant(rr_ref(eg, bus.s));
                else model_idle();
            end else if (own && mcnt >= MAXT - 1 && oth) begin
                model_grant(rr_ref(eg, bus.s));
            end else begin
                mcnt = (mcnt < 255) ? mcnt + 1 : 255;
                ey = bus.cmd[2*eg +: 2];
            end
        end
        exp_q.push_back({ey, 4'(eg), ev});
        @(posedge clock);
        #1;
    endtask

    // Scoreboard: compare each registered output against the model's prediction.
    always begin
        @(posedge clock);
        #1;
        if (reset_n && exp_q.size() != 0) begin
            sb_exp = exp_q.pop_front();
            checks++;
            if ({bus.y, bus.gnt, bus.valid} !== sb_exp) begin
                errors++;
                $display("FAIL scoreboard t=%0t: y=%b gnt=%0d valid=%b expected y=%b gnt=%0d valid=%b",
                         $time, bus.y, bus.gnt, bus.valid, sb_exp[6:5], sb_exp[4:1], sb_exp[0]);
            end
        end
    end

    task automatic do_reset();
        reset_n = 1'b0;
        bus.m = 1'b0; bus.s = 16'd0; bus.cmd = 32'd0;
        exp_q.delete();
        model_idle();
        mlast = 15;
        @(posedge clock);
        #1;
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        int bad;
        do_reset();
        checks++;
        if ({bus.y, bus.gnt, bus.valid} !== 7'd0) begin
            errors++;
            $display("FAIL reset_values: y=%b gnt=%0d valid=%b expected all 0", bus.y, bus.gnt, bus.valid);
        end
        bad = 0;
        repeat (5) begin
            step();
            if ({bus.y, bus.gnt, bus.valid} !== 7'd0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL idle_quiet: %0d non-idle cycles, expected 0", bad);
        end
    endtask

    task automatic test_async_reset();
        bus.s = 16'h0008;
        step();
        step();
        checks++;
        if (bus.gnt !== 4'd3 || bus.valid !== 1'b1) begin
            errors++;
            $display("FAIL async_pre: gnt=%0d valid=%b expected 3/1", bus.gnt, bus.valid);
        end
        #2;
        reset_n = 1'b0;
        exp_q.delete();
        #1;
        checks++;
        if ({bus.y, bus.gnt, bus.valid} !== 7'd0) begin
            errors++;
            $display("FAIL async_reset: y=%b gnt=%0d valid=%b expected all 0 before clock",
                     bus.y, bus.gnt, bus.valid);
        end
        model_idle();
        mlast = 15;
        bus.s = 16'd0;
        #1;
        reset_n = 1'b1;
    endtask

    task automatic test_hold_release();
        int n;
        bus.cmd = 32'd0;
        bus.cmd[5:4] = 2'b10;
        bus.cmd[9:8] = 2'b01;
        bus.s = 16'h0014;
        step();
        checks++;
        if (bus.gnt !== 4'd2 || bus.y !== 2'b10 || bus.valid !== 1'b1) begin
            errors++;
            $display("FAIL hold_first_grant: gnt=%0d y=%b valid=%b expected 2/10/1", bus.gnt, bus.y, bus.valid);
        end
        bus.s = 16'h0010;
        bus.cmd[5:4] = 2'b11;
        n = 0;
        while (n < 10) begin
            step();
            n++;
            if (bus.gnt !== 4'd2) break;
        end
        checks++;
        if (n != 4 || bus.gnt !== 4'd4 || bus.y !== 2'b01) begin
            errors++;
            $display("FAIL hold_release: switched after %0d cycles to gnt=%0d y=%b, expected 4 cycles gnt=4 y=01",
                     n, bus.gnt, bus.y);
        end
    endtask

    task automatic test_preempt();
        int prev, run, nrun;
        int rg[$];
        int rl[$];
        do_reset();
        bus.cmd = 32'hC3A5_5A3C;
        bus.s = 16'h8001;
        prev = -1;
        run = 0;
        repeat (80) begin
            step();
            if (int'(bus.gnt) == prev) run++;
            else begin
                if (prev != -1) begin rg.push_back(prev); rl.push_back(run); end
                prev = int'(bus.gnt);
                run = 1;
            end
        end
        nrun = rg.size();
        checks++;
        if (nrun < 4) begin
            errors++;
            $display("FAIL preempt_count: %0d complete tenures, expected at least 4", nrun);
        end
        for (int i = 0; i < nrun; i++) begin
            checks++;
            if (rl[i] != MAXT || rg[i] != ((i % 2 == 0) ? 0 : 15)) begin
                errors++;
                $display("FAIL preempt_tenure%0d: gnt=%0d len=%0d expected gnt=%0d len=%0d",
                         i, rg[i], rl[i], (i % 2 == 0) ? 0 : 15, MAXT);
            end
        end
    endtask

    task automatic test_master();
        int bad;
        do_reset();
        bus.cmd = 32'h0000_4003;
        bus.s = 16'h0080;
        step();
        checks++;
        if (bus.gnt !== 4'd7 || bus.y !== 2'b01) begin
            errors++;
            $display("FAIL master_pre: gnt=%0d y=%b expected 7/01", bus.gnt, bus.y);
        end
        bus.m = 1'b1;
        step();
        checks++;
        if (bus.y !== 2'b11 || bus.gnt !== 4'd0 || bus.valid !== 1'b1) begin
            errors++;
            $display("FAIL master_override: y=%b gnt=%0d valid=%b expected 11/0/1", bus.y, bus.gnt, bus.valid);
        end
        bus.m = 1'b0;
        bus.s = 16'h0100;
        step();
        checks++;
        if (bus.gnt !== 4'd8 || bus.valid !== 1'b1) begin
            errors++;
            $display("FAIL master_release: gnt=%0d valid=%b expected 8/1", bus.gnt, bus.valid);
        end
        bus.s = 16'd0;
        bad = 0;
        repeat (HOLD - 1) begin
            step();
            if (bus.gnt !== 4'd8 || bus.valid !== 1'b1) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL master_fresh_hold: %0d cycles lost the grant, expected 0", bad);
        end
        step();
        checks++;
        if (bus.valid !== 1'b0 || bus.y !== 2'b00) begin
            errors++;
            $display("FAIL master_hold_end: valid=%b y=%b expected 0/00", bus.valid, bus.y);
        end
    endtask

    task automatic test_single();
        int bad;
        do_reset();
        bus.cmd = 32'h0000_1000;
        bus.s = 16'h0040;
        bad = 0;
        repeat (40) begin
            step();
            if (bus.gnt !== 4'd6 || bus.valid !== 1'b1 || bus.y !== 2'b01) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL single_owner: %0d bad cycles, expected 0", bad);
        end
        bus.cmd = 32'h0000_3000;
        step();
        checks++;
        if (bus.y !== 2'b11) begin
            errors++;
            $display("FAIL single_track: y=%b expected 11", bus.y);
        end
        bus.s = 16'd0;
        step();
        checks++;
        if ({bus.y, bus.gnt, bus.valid} !== 7'd0) begin
            errors++;
            $display("FAIL single_idle: y=%b gnt=%0d valid=%b expected all 0", bus.y, bus.gnt, bus.valid);
        end
    endtask

    task automatic test_random();
        do_reset();
        repeat (600) begin
            bus.m = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 7) == 0) bus.s = 16'($urandom & $urandom & $urandom);
            bus.cmd = $urandom;
            step();
        end
    endtask

    initial begin
        test_reset();
        test_async_reset();
        test_hold_release();
        test_preempt();
        test_master();
        test_single();
        test_random();
        repeat (2) @(posedge clock);
        #2;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/lamp_arbiter.md
Name: lamp_arbiter

Overview:
- Sequential arbiter sharing the single 2-bit lamp command output among 16 switches.
- Each switch drives a 2-bit command; its sensor is its request line.
- Replaces fixed-priority selection with round-robin grants, a minimum hold time and a maximum tenure.
- Master switch m overrides everything and forces switch a (int[1:0]).
- All outputs are registered and feed the lamp driver directly.

Parameters:
- HOLD, 4: minimum cycles a grant is kept once issued, even if its request drops. Range 1..MAXT.
- MAXT, 16: maximum cycles an owner keeps the grant while other requests are pending. Range 2..255.

Ports:
- clock  input  1  rising-edge clock
- reset_n  input  1  asynchronous, active-low reset
- m  input  1  master switch; 1 forces int[1:0] to the output
- s  input  16  sensor/request vector; s[k]=1 means switch k requests
- int  input  32  packed switch commands; switch k = int[2k+1:2k]
- y  output  2  registered lamp command
- gnt  output  4  registered index of the current owner (0 in MASTER/IDLE)
- valid  output  1  1 when y carries an owner or master command

Behaviour:
- Reset (reset_n=0, asynchronous): state=IDLE, y=00, gnt=0, valid=0, cnt=0, last=15.
  - last=15 makes the first round-robin scan start at index 0.
- States:
  - IDLE: no owner.
  - OWN: switch gnt owns the lamp.
  - MASTER: m active.
- Timing: all decisions sample s, m and int at the rising edge; effects are visible after that edge (1-cycle latency).
- While owning, y follows the owner's current int slice each cycle, delayed 1 cycle.
- m=1 at an edge, from any state:
  - state<=MASTER, y<=int[1:0], gnt<=0, valid<=1, cnt<=0.
  - last unchanged.
  - m has precedence over every other event in the same cycle.
- RR(x): first index with s[i]=1, scanning (x+1) mod 16 upward with wrap. Undefined if s=0; callers check first.
- IDLE, m=0:
  - s!=0: state<=OWN, gnt<=RR(last), last<=RR(last), cnt<=0, y<=int slice of the new owner, valid<=1.
  - s=0: stay; y=00, valid=0.
- OWN, m=0, with g=gnt:
  - Release when s[g]=0 and cnt>=HOLD-1:
    - other s bits set: grant RR(g), last<=RR(g), cnt<=0.
    - s=0: state<=IDLE, y<=00, valid<=0, gnt<=0.
  - Preempt when s[g]=1, cnt>=MAXT-1 and any s[i]=1 with i!=g: grant RR(g) (never g itself), cnt<=0.
  - Otherwise: stay, cnt<=cnt+1 saturating at 255, y<=int[2g+1:2g].
    - This covers s[g]=0 with cnt<HOLD-1: the grant is held and y still tracks int[g].
    - If g is the only requester, it keeps the grant beyond MAXT.
- MASTER, m=0 (master released):
  - s!=0: behave as the IDLE grant using last.
  - s=0: go to IDLE with y<=00, valid<=0.
- A new grant always gets a full HOLD window starting at cnt=0.
- Wrap-around: RR from g=15 scans 0,1,...
- Reset asserted mid-grant returns immediately to reset values.
- X-free: every register is assigned in every state.

Test Plan:
- Reset, then s=0, m=0 for 5 cycles -> y=00, valid=0, gnt=0 throughout.
- Pulse reset_n low mid-cycle -> outputs go to 0 immediately, without waiting for a clock.
- s=0x0014 (bits 2 and 4), int[5:4]=10 -> cycle 1: gnt=2, y=10, valid=1. Drop s[2] after 1 cycle (HOLD=4) -> gnt stays 2 until cnt=3, then gnt=4, y=int[9:8].
- Preemption: s=0x8001 held constant, HOLD=4, MAXT=16 -> gnt alternates 0 and 15, each tenure exactly 16 cycles. Wrap 15->0 verified.
- Master override: while gnt=7 owns, assert m with int[1:0]=11 -> next cycle y=11, gnt=0, valid=1. Release m with s=0x0100 -> gnt=8 with a fresh HOLD window.
- Single requester: s=0x0040 for 40 cycles -> gnt=6 for all 40 cycles with no preemption. Change int[13:12] 01->11 -> y follows one cycle later. Then s=0 after HOLD -> IDLE, y=00, valid=0.
